rob_slot_ctrl: RTL and testbench

- Reorder-buffer slot controller; converts binary slot pointers into one-hot entry strobes (binary-to-one-hot decode) for the ROB entry array.
- Allocates slots in order at the tail and records out-of-order completion by binary index.
- Retires completed slots in order from the head with a valid/ready handshake.
- Sits between dispatch (allocation), execution units (completion) and commit logic (retirement).

---
 rtl/rob_slot_ctrl_pkg.sv | 11 +
 rtl/rob_bin2onehot.sv | 18 +
 rtl/rob_slot_ctrl.sv | 82 ++++++++
 tb/tb_rob_slot_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rob_slot_ctrl_pkg.sv
// Shared defaults for the ROB slot controller: guarded size macros plus package constants.
`ifndef ROB_SLOT_CTRL_DEFS
`define ROB_SLOT_CTRL_DEFS
`define ROB_N_DEFAULT 4
`define ROB_PTR_DEFAULT 2
`endif

package rob_slot_ctrl_pkg;
  localparam int ROB_N   = `ROB_N_DEFAULT;
  localparam int ROB_PTR = `ROB_PTR_DEFAULT;
endpackage

// File: rtl/rob_bin2onehot.sv
// Binary slot index to one-hot entry strobe; all-zero when en is low.
module rob_bin2onehot
  import rob_slot_ctrl_pkg::*;
#(
  parameter int N   = ROB_N,
  parameter int PTR = ROB_PTR
) (
  input  logic [PTR-1:0] idx,
  input  logic           en,
  output logic [N-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rob_slot_ctrl.sv
// ROB slot controller: in-order allocate at tail, out-of-order completion, in-order retire at head.
module rob_slot_ctrl
  import rob_slot_ctrl_pkg::*;
#(
  parameter int N   = ROB_N,
  parameter int PTR = ROB_PTR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           alloc_valid,
  output logic           alloc_ready,
  output logic [PTR-1:0] alloc_idx,
  output logic [N-1:0]   alloc_onehot,
  input  logic           done_valid,
  input  logic [PTR-1:0] done_idx,
  output logic           done_err,
  output logic           retire_valid,
  input  logic           retire_ready,
  output logic [PTR-1:0] retire_idx,
  output logic [N-1:0]   retire_onehot,
  output logic [N-1:0]   valid_vec,
  output logic [N-1:0]   done_vec,
  output logic [PTR:0]   count,
  output logic           full,
  output logic           empty
);

  // Handshakes: a transfer fires on the cycle where valid and ready are both high.
  logic [PTR-1:0] head, tail;
  logic [PTR:0]   cnt_q;
  logic [N-1:0]   valid_q, done_q, done_set;
  logic           err_q;
  logic           alloc_fire, retire_fire, done_hit;

  assign full         = (cnt_q == (PTR+1)'(N));
  assign empty        = (cnt_q == '0);
  assign alloc_ready  = !full;
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign retire_valid = valid_q[head] & done_q[head];
  assign retire_fire  = retire_valid & retire_ready;
  assign done_hit     = done_valid & valid_q[done_idx] & !flush;

  assign alloc_idx  = tail;
  assign retire_idx = head;
  assign count      = cnt_q;
  assign valid_vec  = valid_q;
  assign done_vec   = done_q;
  assign done_err   = err_q;

  rob_bin2onehot #(.N(N), .PTR(PTR)) u_alloc_dec (
    .idx(tail), .en(alloc_fire), .onehot(alloc_onehot)
  );

  rob_bin2onehot #(.N(N), .PTR(PTR)) u_retire_dec (
    .idx(head), .en(retire_fire), .onehot(retire_onehot)
  );

  rob_bin2onehot #(.N(N), .PTR(PTR)) u_done_dec (
    .idx(done_idx), .en(done_hit), .onehot(done_set)
  );

  // Retire reads the registered done bit, so a same-cycle completion to head retires next cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (alloc_fire)  tail <= tail + 1'b1;
      if (retire_fire) head <= head + 1'b1;
      cnt_q   <= cnt_q + (PTR+1)'(alloc_fire) - (PTR+1)'(retire_fire);
      valid_q <= (valid_q & ~retire_onehot) | alloc_onehot;
      done_q  <= (done_q | done_set) & ~retire_onehot & ~alloc_onehot;
      err_q   <= done_valid & ~valid_q[done_idx];
    end
  end

endmodule

// File: tb/tb_rob_slot_ctrl.sv
// Bench for rob_slot_ctrl: queue-based reference model, strobe scoreboard, directed plus random traffic.
module tb_rob_slot_ctrl;
  localparam int N   = 4;
  localparam int PTR = 2;
  localparam int W   = PTR + N;

  logic           clk = 1'b0;
  logic           rst, flush, alloc_valid, done_valid, retire_ready;
  logic [PTR-1:0] done_idx;
  logic           alloc_ready, done_err, retire_valid, full, empty;
  logic [PTR-1:0] alloc_idx, retire_idx;
  logic [N-1:0]   alloc_onehot, retire_onehot, valid_vec, done_vec;
  logic [PTR:0]   count;

  rob_slot_ctrl #(.N(N), .PTR(PTR)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_idx(alloc_idx), .alloc_onehot(alloc_onehot),
    .done_valid(done_valid), .done_idx(done_idx), .done_err(done_err),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .retire_idx(retire_idx), .retire_onehot(retire_onehot),
    .valid_vec(valid_vec), .done_vec(done_vec), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_alloc_q[$];
  logic [W-1:0] exp_retire_q[$];

  // Reference model: slots in age order plus per-slot done flags.
  int occ_q[$];
  bit done_m[N];
  int tail_m = 0;
  bit err_m  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int head_m();
    return (tail_m - occ_q.size() + N) % N;
  endfunction

  function automatic bit is_alloc(input int s);
    foreach (occ_q[i]) if (occ_q[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] vmask();
    logic [N-1:0] m = '0;
    foreach (occ_q[i]) m[occ_q[i]] = 1'b1;
    return m;
  endfunction

  function automatic logic [N-1:0] dmask();
    logic [N-1:0] m = '0;
    foreach (occ_q[i]) if (done_m[occ_q[i]]) m[occ_q[i]] = 1'b1;
    return m;
  endfunction

  function automatic logic [N-1:0] oh(input int s);
    logic [N-1:0] m = '0;
    m[s] = 1'b1;
    return m;
  endfunction

  task automatic check_state();
    int sz = occ_q.size();
    bit rv = (sz > 0) && done_m[occ_q[0]];
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == N));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("alloc_ready", 32'(alloc_ready), 32'(sz < N));
    chk("alloc_idx", 32'(alloc_idx), 32'(tail_m));
    chk("retire_idx", 32'(retire_idx), 32'(head_m()));
    chk("retire_valid", 32'(retire_valid), 32'(rv));
    chk("valid_vec", 32'(valid_vec), 32'(vmask()));
    chk("done_vec", 32'(done_vec), 32'(dmask()));
    chk("done_err", 32'(done_err), 32'(err_m));
  endtask

  // One clock of stimulus: drive, check pre-edge state, predict strobes, advance model.
  task automatic cycle(input bit r, input bit f, input bit av, input bit dv,
                       input int di, input bit rr);
    bit a_fire, r_fire, hit;
    int h;
    @(negedge clk);
    rst = r; flush = f; alloc_valid = av; done_valid = dv;
    done_idx = PTR'(di); retire_ready = rr;
    #1;
    check_state();
    h = head_m();
    a_fire = av && (occ_q.size() < N);
    r_fire = rr && (occ_q.size() > 0) && done_m[occ_q[0]];
    if (a_fire) exp_alloc_q.push_back({PTR'(tail_m), oh(tail_m)});
    if (r_fire) exp_retire_q.push_back({PTR'(h), oh(h)});
    if (r || f) begin
      occ_q.delete();
      foreach (done_m[i]) done_m[i] = 1'b0;
      tail_m = 0;
      err_m  = 1'b0;
    end else begin
      hit   = dv && is_alloc(di);
      err_m = dv && !hit;
      if (hit) done_m[di] = 1'b1;
      if (r_fire) begin
        done_m[occ_q[0]] = 1'b0;
        void'(occ_q.pop_front());
      end
      if (a_fire) begin
        occ_q.push_back(tail_m);
        done_m[tail_m] = 1'b0;
        tail_m = (tail_m + 1) % N;
      end
    end
  endtask

  task automatic idle(input bit rr);
    cycle(0, 0, 0, 0, 0, rr);
  endtask

  // Monitor: pops an expected strobe whenever the DUT shows one.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (alloc_onehot != '0) begin
        if (exp_alloc_q.size() == 0) chk("alloc_strobe_unexpected", 32'({alloc_idx, alloc_onehot}), 32'(0));
        else begin
          e = exp_alloc_q.pop_front();
          chk("alloc_strobe", 32'({alloc_idx, alloc_onehot}), 32'(e));
        end
      end
      if (retire_onehot != '0) begin
        if (exp_retire_q.size() == 0) chk("retire_strobe_unexpected", 32'({retire_idx, retire_onehot}), 32'(0));
        else begin
          e = exp_retire_q.pop_front();
          chk("retire_strobe", 32'({retire_idx, retire_onehot}), 32'(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; done_valid = 1'b0;
    done_idx = '0; retire_ready = 1'b0;
    @(posedge clk);
    cycle(1, 0, 0, 0, 0, 0);
    idle(0);

    // Fill, then out-of-order completion and in-order retire
    repeat (4) cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 2, 1);
    cycle(0, 0, 0, 1, 0, 1);
    repeat (2) idle(1);
    cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 0, 0, 1, 3, 1);
    repeat (4) idle(1);

    // Move pointers to 3, then wrap-around allocation
    cycle(0, 1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    for (int s = 0; s < 3; s++) cycle(0, 0, 0, 1, s, 0);
    repeat (4) idle(1);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 3, 0);
    cycle(0, 0, 0, 1, 0, 0);
    repeat (3) idle(1);

    // Simultaneous allocate and retire at count 2
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 1, 0);
    cycle(0, 0, 1, 0, 0, 1);
    idle(0);

    // Completion to an unallocated slot, and to a slot being allocated
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0, 0);
    idle(0);

    // Flush, then reset, each with an allocation in flight
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    idle(0);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 1, 1, 0);
    idle(0);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, N-1)), $urandom_range(0, 3) != 0);
    end
    repeat (2) idle(0);

    chk("alloc_queue_drained", 32'(exp_alloc_q.size()), 32'(0));
    chk("retire_queue_drained", 32'(exp_retire_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
